axi4_lite_clint: RTL and testbench
==================================

AXI4_LITE_CLINT -- requirements
Module: axi4_lite_clint

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0200_0000, base of the 16-byte register window.
REQ-002 Parameter R_DELAY_TIME, default 1, cycles from AR handshake to RVALID; legal range 1..15.
REQ-003 Parameter W_DELAY_TIME, default 1, cycles from AW+W captured to BVALID; legal range 1..15.
REQ-004 Ports, in order:
- clk  in  1  sole clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- ARVALID  in  1  read address valid.
- ARREADY  out  1  read address ready.
- ARADDR  in  32  read byte address.
- RVALID  out  1  read data valid.
- RREADY  in  1  read data ready.
- RDATA  out  32  read data.
- RRESP  out  2  read response.
- AWVALID  in  1  write address valid.
- AWREADY  out  1  write address ready.
- AWADDR  in  32  write byte address.
- WVALID  in  1  write data valid.
- WREADY  out  1  write data ready.
- WDATA  in  32  write data.
- WSTRB  in  4  byte enables.
- BVALID  out  1  write response valid.
- BREADY  in  1  write response ready.
- BRESP  out  2  write response.
- mtip  out  1  machine timer interrupt pending.

Function
REQ-005 Register map (offset = addr - BASE_ADDR): 0x0 MTIME_LO, 0x4 MTIME_HI, 0x8 MTIMECMP_LO, 0xC MTIMECMP_HI; all read/write.
REQ-006 mtime is 64 bits and increments by 1 every cycle out of reset; it wraps from all-ones to 0; carry from LO into HI is in the same cycle.
REQ-007 Read FSM states: R_IDLE (ARREADY=1), R_WAIT (delay counter running), R_RESP (RVALID=1); ARREADY=0 outside R_IDLE.
REQ-008 Transitions: R_IDLE->R_WAIT on ARVALID&ARREADY; R_WAIT->R_RESP when counter reaches R_DELAY_TIME-1; R_RESP->R_IDLE on RREADY.
REQ-009 RDATA/RRESP are captured at the AR handshake cycle (register value before that cycle's increment) and are held stable while RVALID=1.
REQ-010 Reading MTIME_LO also latches mtime[63:32] into a shadow register; a subsequent read of MTIME_HI returns the shadow value; reset clears the shadow to 0.
REQ-011 Write FSM states: W_IDLE, W_WAIT, W_RESP; in W_IDLE AWREADY=1 until AW is captured and WREADY=1 until W is captured, independently, in either order or the same cycle.
REQ-012 W_IDLE->W_WAIT once both AW and W are captured; W_WAIT->W_RESP when counter reaches W_DELAY_TIME-1; W_RESP->W_IDLE on BREADY.
REQ-013 The register write commits on the W_WAIT->W_RESP edge, byte-wise per WSTRB; WSTRB=4'b0000 writes nothing but responds normally.
REQ-014 A commit to MTIME_LO/HI in the same cycle as the increment: the written bytes take the written value, unwritten bytes take the incremented value; incrementing resumes from the result on the next cycle.
REQ-015 Responses: 2'b00 OKAY for aligned in-window access; 2'b10 SLVERR for addr[1:0]!=0 inside window; 2'b11 DECERR outside window; on SLVERR/DECERR RDATA=0 and writes commit nothing.
REQ-016 mtip is registered: mtip = (mtime >= mtimecmp) evaluated on the previous cycle's values, unsigned 64-bit compare.
REQ-017 Read and write channels are fully independent; a read in flight does not stall the write FSM and vice versa.

Reset
REQ-018 On rst: mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, shadow=0, mtip=0, both FSMs idle, ARREADY=1, AWREADY=1, WREADY=1, RVALID=0, BVALID=0, RDATA=0, RRESP=0, BRESP=0.
REQ-019 Reset asserted mid-transaction aborts it with no response and no commit; deassertion takes effect on the next rising edge.

Verification
REQ-020 Release reset, read 0x0200_0000 at cycle 10 with R_DELAY_TIME=1 -> RVALID next cycle, RDATA=10, RRESP=00.
REQ-021 Write MTIME_LO=32'hFFFF_FFFF, MTIME_HI=0, then read LO then HI -> HI read returns shadow latched by the LO read (1 if LO has wrapped, else 0).
REQ-022 Write MTIMECMP_HI=0, MTIMECMP_LO=100 -> mtip rises exactly one cycle after mtime reaches 100; write MTIMECMP_HI=1 -> mtip falls.
REQ-023 W before AW by 3 cycles, WSTRB=4'b0011, WDATA=32'h1234_5678 to MTIMECMP_LO (prior all-ones) -> MTIMECMP_LO=32'hFFFF_5678, BRESP=00.
REQ-024 Read 0x0200_0010 -> RRESP=11, RDATA=0; write 0x0200_0002 -> BRESP=10, no register change.
REQ-025 Hold RREADY=0 for 5 cycles in R_RESP while a write completes -> RVALID/RDATA stable, BVALID asserts independently; assert rst mid-read -> RVALID=0 immediately.

Source files
------------

// File: rtl/axi4_lite_clint.sv
// AXI4-Lite CLINT timer: 64-bit mtime/mtimecmp in a 16-byte window with
// independent read/write channels, fixed response latency and a registered mtip.
module axi4_lite_clint #(
   parameter logic [31:0] BASE_ADDR    = 32'h0200_0000,
   parameter int          R_DELAY_TIME = 1,
   parameter int          W_DELAY_TIME = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ARVALID,
   output logic        ARREADY,
   input  logic [31:0] ARADDR,
   output logic        RVALID,
   input  logic        RREADY,
   output logic [31:0] RDATA,
   output logic [1:0]  RRESP,
   input  logic        AWVALID,
   output logic        AWREADY,
   input  logic [31:0] AWADDR,
   input  logic        WVALID,
   output logic        WREADY,
   input  logic [31:0] WDATA,
   input  logic [3:0]  WSTRB,
   output logic        BVALID,
   input  logic        BREADY,
   output logic [1:0]  BRESP,
   output logic        mtip
);
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;
   localparam logic [3:0] R_LAST      = 4'(R_DELAY_TIME - 1);
   localparam logic [3:0] W_LAST      = 4'(W_DELAY_TIME - 1);

   typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;
   typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} w_state_t;

   function automatic logic [1:0] decode_resp(input logic [31:0] addr);
      logic [31:0] off;
      off = addr - BASE_ADDR;
      if (off >= 32'd16)          return RESP_DECERR;
      else if (off[1:0] != 2'b00) return RESP_SLVERR;
      else                        return RESP_OKAY;
   endfunction

   r_state_t    r_rstate, w_rstate_next;
   w_state_t    r_wstate, w_wstate_next;
   logic [3:0]  r_rcnt, r_wcnt;
   logic [63:0] r_mtime, r_mtimecmp, w_mtime_inc, w_mtime_next, w_mtimecmp_next;
   logic [31:0] r_shadow, r_rdata, r_awaddr, r_wdata, w_ar_data, w_wmask;
   logic [3:0]  r_wstrb;
   logic [1:0]  r_rresp, r_bresp, w_ar_resp, w_wresp, w_ar_idx, w_aw_idx;
   logic        r_mtip, r_aw_done, r_w_done;
   logic        w_ar_hs, w_aw_hs, w_w_hs, w_both, w_wlast, w_commit;

   assign ARREADY = (r_rstate == R_IDLE);
   assign RVALID  = (r_rstate == R_RESP);
   assign RDATA   = r_rdata;
   assign RRESP   = r_rresp;
   assign AWREADY = (r_wstate == W_IDLE) && !r_aw_done;
   assign WREADY  = (r_wstate == W_IDLE) && !r_w_done;
   assign BVALID  = (r_wstate == W_RESP);
   assign BRESP   = r_bresp;
   assign mtip    = r_mtip;

   // ---------------- read channel ----------------
   assign w_ar_hs   = ARVALID && ARREADY;
   assign w_ar_idx  = 2'((ARADDR - BASE_ADDR) >> 2);
   assign w_ar_resp = decode_resp(ARADDR);

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      w_ar_data = '0;
      if (w_ar_resp == RESP_OKAY) begin
         case (w_ar_idx)
            2'd0:    w_ar_data = r_mtime[31:0];
            2'd1:    w_ar_data = r_shadow;
            2'd2:    w_ar_data = r_mtimecmp[31:0];
            default: w_ar_data = r_mtimecmp[63:32];
         endcase
      end
   end

   always_comb begin
      w_rstate_next = r_rstate;
      case (r_rstate)
         R_IDLE:  if (w_ar_hs)          w_rstate_next = R_WAIT;
         R_WAIT:  if (r_rcnt == R_LAST) w_rstate_next = R_RESP;
         R_RESP:  if (RREADY)           w_rstate_next = R_IDLE;
         default:                       w_rstate_next = R_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rstate <= R_IDLE;
         r_rcnt   <= '0;
         r_rdata  <= '0;
         r_rresp  <= RESP_OKAY;
         r_shadow <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
         r_rstate <= w_rstate_next;
         r_rcnt   <= (r_rstate == R_WAIT) ? r_rcnt + 4'd1 : 4'd0;
         if (w_ar_hs) begin
            r_rdata <= w_ar_data;
            r_rresp <= w_ar_resp;
            if (w_ar_resp == RESP_OKAY && w_ar_idx == 2'd0) r_shadow <= r_mtime[63:32];
         end
      end
   end

   // ---------------- write channel ----------------
   assign w_aw_hs  = AWVALID && AWREADY;
   assign w_w_hs   = WVALID && WREADY;
   assign w_both   = (r_aw_done || w_aw_hs) && (r_w_done || w_w_hs);
   assign w_wlast  = (r_wstate == W_WAIT) && (r_wcnt == W_LAST);
   assign w_wresp  = decode_resp(r_awaddr);
   assign w_aw_idx = 2'((r_awaddr - BASE_ADDR) >> 2);
   assign w_commit = w_wlast && (w_wresp == RESP_OKAY);
   assign w_wmask  = {{8{r_wstrb[3]}}, {8{r_wstrb[2]}}, {8{r_wstrb[1]}}, {8{r_wstrb[0]}}};

   always_comb begin
      w_wstate_next = r_wstate;
      case (r_wstate)
         W_IDLE:  if (w_both)           w_wstate_next = W_WAIT;
         W_WAIT:  if (r_wcnt == W_LAST) w_wstate_next = W_RESP;
         W_RESP:  if (BREADY)           w_wstate_next = W_IDLE;
         default:                       w_wstate_next = W_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wstate  <= W_IDLE;
         r_wcnt    <= '0;
         r_aw_done <= 1'b0;
         r_w_done  <= 1'b0;
         r_awaddr  <= '0;
         r_wdata   <= '0;
         r_wstrb   <= '0;
         r_bresp   <= RESP_OKAY;
      end else begin
         r_wstate <= w_wstate_next;
         r_wcnt   <= (r_wstate == W_WAIT) ? r_wcnt + 4'd1 : 4'd0;
         if (w_aw_hs) r_awaddr <= AWADDR;
         if (w_w_hs) begin
            r_wdata <= WDATA;
            r_wstrb <= WSTRB;
         end
         if (w_both) begin
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
         end else begin
            if (w_aw_hs) r_aw_done <= 1'b1;
            if (w_w_hs)  r_w_done  <= 1'b1;
         end
         if (w_wlast) r_bresp <= w_wresp;
      end
   end

   // ---------------- timer ----------------
   // Unwritten mtime bytes follow the increment so a commit never loses a tick.
   always_comb begin
      w_mtime_inc     = r_mtime + 64'd1;
      w_mtime_next    = w_mtime_inc;
      w_mtimecmp_next = r_mtimecmp;
      if (w_commit) begin
         case (w_aw_idx)
            2'd0:    w_mtime_next[31:0]     = (r_wdata & w_wmask) | (w_mtime_inc[31:0]  & ~w_wmask);
            2'd1:    w_mtime_next[63:32]    = (r_wdata & w_wmask) | (w_mtime_inc[63:32] & ~w_wmask);
            2'd2:    w_mtimecmp_next[31:0]  = (r_wdata & w_wmask) | (r_mtimecmp[31:0]   & ~w_wmask);
            default: w_mtimecmp_next[63:32] = (r_wdata & w_wmask) | (r_mtimecmp[63:32]  & ~w_wmask);
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_mtime    <= '0;
         r_mtimecmp <= '1;
         r_mtip     <= 1'b0;
      end else begin
         r_mtime    <= w_mtime_next;
         r_mtimecmp <= w_mtimecmp_next;
         r_mtip     <= (r_mtime >= r_mtimecmp);
      end
   end
endmodule

// File: tb/tb_axi4_lite_clint.sv
// Directed self-checking bench for axi4_lite_clint; expected values are hand-derived
// from the bench's own edge counter (edge k after reset release sees mtime = k-1).
module tb_axi4_lite_clint;
   localparam logic [31:0] BASE = 32'h0200_0000;

   logic        clk, rst;
   logic        ARVALID, ARREADY, RVALID, RREADY;
   logic [31:0] ARADDR, RDATA;
   logic [1:0]  RRESP;
   logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
   logic [31:0] AWADDR, WDATA;
   logic [3:0]  WSTRB;
   logic [1:0]  BRESP;
   logic        mtip;

   int          n_vec = 0;
   int          n_miss = 0;
   int          cyc = 0;
   int          hs, cc, c_lo, t;
   logic [31:0] rd;
   logic [1:0]  rr, br;

   axi4_lite_clint dut (
      .clk(clk), .rst(rst),
      .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR),
      .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP),
      .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR),
      .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB),
      .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
      .mtip(mtip)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (rst) cyc = 0;
      else     cyc = cyc + 1;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_miss++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic do_read(input logic [31:0] addr, output logic [31:0] data,
                          output logic [1:0] resp, output int hs_edge);
      int tt;
      tt = 0;
      while (!ARREADY && tt < 32) begin @(posedge clk); #1; tt++; end
      ARADDR = addr; ARVALID = 1'b1;
      @(posedge clk); #1;
      hs_edge = cyc; ARVALID = 1'b0;
      tt = 0;
      while (!RVALID && tt < 32) begin @(posedge clk); #1; tt++; end
      check("r_timeout", 64'(RVALID), 64'd1);
      data = RDATA; resp = RRESP;
      RREADY = 1'b1; @(posedge clk); #1; RREADY = 1'b0;
   endtask

   task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int lead, output logic [1:0] resp, output int commit_edge);
      int tt;
      tt = 0;
      while (!(AWREADY && WREADY) && tt < 32) begin @(posedge clk); #1; tt++; end
      WDATA = data; WSTRB = strb; WVALID = 1'b1;
      if (lead > 0) begin
         @(posedge clk); #1; WVALID = 1'b0;
         check("w_first_wready", 64'(WREADY), 64'd0);
         check("w_first_awready", 64'(AWREADY), 64'd1);
         repeat (lead - 1) begin @(posedge clk); #1; end
      end
      AWADDR = addr; AWVALID = 1'b1;
      @(posedge clk); #1; AWVALID = 1'b0; WVALID = 1'b0;
      tt = 0;
      while (!BVALID && tt < 32) begin @(posedge clk); #1; tt++; end
      check("b_timeout", 64'(BVALID), 64'd1);
      commit_edge = cyc; resp = BRESP;
      BREADY = 1'b1; @(posedge clk); #1; BREADY = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      ARVALID = 0; ARADDR = '0; RREADY = 0;
      AWVALID = 0; AWADDR = '0; WVALID = 0; WDATA = '0; WSTRB = '0; BREADY = 0;
      repeat (3) @(posedge clk); #1;

      // Reset state
      check("rst_ready", {61'd0, ARREADY, AWREADY, WREADY}, 64'd7);
      check("rst_valid_mtip", {61'd0, RVALID, BVALID, mtip}, 64'd0);
      check("rst_rdata", 64'(RDATA), 64'd0);
      check("rst_resp", {60'd0, RRESP, BRESP}, 64'd0);
      rst = 1'b0;

      // Read MTIME_LO with handshake on edge 11 -> mtime 10, RVALID one cycle after R_WAIT
      while (cyc < 10) begin @(posedge clk); #1; end
      ARADDR = BASE; ARVALID = 1'b1;
      @(posedge clk); #1; ARVALID = 1'b0;
      check("r_wait_state", {62'd0, RVALID, ARREADY}, 64'd0);
      @(posedge clk); #1;
      check("r_first_valid", 64'(RVALID), 64'd1);
      check("r_first_data", 64'(RDATA), 64'd10);
      check("r_first_resp", 64'(RRESP), 64'd0);
      RREADY = 1'b1; @(posedge clk); #1; RREADY = 1'b0;
      check("r_back_idle", {62'd0, RVALID, ARREADY}, 64'd1);

      // mtimecmp = 100 -> mtip rises on edge 101 (mtime reached 100 after edge 100)
      do_write(BASE + 32'hC, 32'd0, 4'hF, 0, br, cc);
      check("cmp_hi_bresp", 64'(br), 64'd0);
      do_write(BASE + 32'h8, 32'd100, 4'hF, 0, br, cc);
      while (cyc < 100) begin @(posedge clk); #1; end
      check("mtip_before", 64'(mtip), 64'd0);
      @(posedge clk); #1;
      check("mtip_rise", 64'(mtip), 64'd1);
      do_write(BASE + 32'hC, 32'd1, 4'hF, 0, br, cc);
      check("mtip_fall", 64'(mtip), 64'd0);

      // W leads AW by 3 cycles, partial strobe onto all-ones MTIMECMP_LO
      do_write(BASE + 32'h8, 32'hFFFF_FFFF, 4'hF, 0, br, cc);
      do_write(BASE + 32'h8, 32'h1234_5678, 4'b0011, 3, br, cc);
      check("strb_bresp", 64'(br), 64'd0);
      do_read(BASE + 32'h8, rd, rr, hs);
      check("strb_merge", 64'(rd), 64'hFFFF_5678);
      check("strb_rresp", 64'(rr), 64'd0);
      do_write(BASE + 32'hC, 32'hABCD_0000, 4'b0000, 0, br, cc);
      check("strb0_bresp", 64'(br), 64'd0);
      do_read(BASE + 32'hC, rd, rr, hs);
      check("strb0_nochange", 64'(rd), 64'd1);

      // MTIME_HI=0 then MTIME_LO=all-ones: LO wraps on the next edge, carrying HI to 1
      do_write(BASE + 32'h4, 32'd0, 4'hF, 0, br, cc);
      do_write(BASE + 32'h0, 32'hFFFF_FFFF, 4'hF, 0, br, c_lo);
      do_read(BASE + 32'h0, rd, rr, hs);
      check("lo_after_wrap", 64'(rd), 64'(32'(hs - c_lo - 2)));
      do_read(BASE + 32'h4, rd, rr, hs);
      check("hi_shadow_carry", 64'(rd), 64'd1);
      do_write(BASE + 32'h4, 32'd5, 4'hF, 0, br, cc);
      do_read(BASE + 32'h4, rd, rr, hs);
      check("hi_shadow_not_live", 64'(rd), 64'd1);

      // Error responses
      do_read(BASE + 32'h10, rd, rr, hs);
      check("decerr_above_resp", 64'(rr), 64'd3);
      check("decerr_above_data", 64'(rd), 64'd0);
      do_read(BASE - 32'h4, rd, rr, hs);
      check("decerr_below_resp", 64'(rr), 64'd3);
      do_read(BASE + 32'h6, rd, rr, hs);
      check("slverr_rd_resp", 64'(rr), 64'd2);
      check("slverr_rd_data", 64'(rd), 64'd0);
      do_write(BASE + 32'h2, 32'hDEAD_BEEF, 4'hF, 0, br, cc);
      check("slverr_wr_resp", 64'(br), 64'd2);
      do_read(BASE + 32'h0, rd, rr, hs);
      check("slverr_no_commit", 64'(rd), 64'(32'(hs - c_lo - 2)));

      // Read held in R_RESP for 5 cycles while a write to the same register completes
      ARADDR = BASE + 32'h8; ARVALID = 1'b1;
      @(posedge clk); #1; ARVALID = 1'b0;
      t = 0;
      while (!RVALID && t < 32) begin @(posedge clk); #1; t++; end
      check("hold_rvalid_start", 64'(RVALID), 64'd1);
      AWADDR = BASE + 32'h8; WDATA = 32'h0000_0042; WSTRB = 4'hF;
      AWVALID = 1'b1; WVALID = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         @(posedge clk); #1;
         AWVALID = 1'b0; WVALID = 1'b0;
         check("hold_rvalid", 64'(RVALID), 64'd1);
         check("hold_rdata", 64'(RDATA), 64'hFFFF_5678);
         if (i == 2) check("hold_bvalid", 64'(BVALID), 64'd1);
      end
      BREADY = 1'b1; @(posedge clk); #1; BREADY = 1'b0;
      check("hold_bdone", 64'(BVALID), 64'd0);
      RREADY = 1'b1; @(posedge clk); #1; RREADY = 1'b0;
      check("hold_rdone", 64'(RVALID), 64'd0);
      do_read(BASE + 32'h8, rd, rr, hs);
      check("hold_write_landed", 64'(rd), 64'h42);

      // Reset mid-read clears RVALID asynchronously and restores register defaults
      ARADDR = BASE; ARVALID = 1'b1;
      @(posedge clk); #1; ARVALID = 1'b0;
      t = 0;
      while (!RVALID && t < 32) begin @(posedge clk); #1; t++; end
      #2 rst = 1'b1;
      #1;
      check("rst_mid_rvalid", 64'(RVALID), 64'd0);
      check("rst_mid_arready", 64'(ARREADY), 64'd1);
      @(posedge clk); #1;
      rst = 1'b0;
      check("rst_mid_mtip", 64'(mtip), 64'd0);
      do_read(BASE + 32'hC, rd, rr, hs);
      check("rst_cmp_hi", 64'(rd), 64'hFFFF_FFFF);
      do_read(BASE + 32'h4, rd, rr, hs);
      check("rst_shadow", 64'(rd), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule
